// File: rtl/frame_accum_pkg.sv
// frame_accum_pkg: shared state encoding, default widths and count-width helper for frame_accum.
package frame_accum_pkg;
  typedef enum logic {ACC, OUT} state_t;
  localparam int DATA_W_DEF = 8;
  localparam int SUM_W_DEF = 16;
  function automatic int cnt_w(input int count);
    return $clog2(count > 1 ? count : 2);
  endfunction
endpackage

// File: rtl/accum_add.sv
// accum_add: zero-extending SUM_W adder; wraps by default, saturates when FRAME_ACCUM_SAT_EN is defined.
module accum_add
  import frame_accum_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int SUM_W = SUM_W_DEF
) (
  input  logic [SUM_W-1:0]  acc,
  input  logic [DATA_W-1:0] beat,
  output logic [SUM_W-1:0]  sum
);
`ifdef FRAME_ACCUM_SAT_EN
  logic [SUM_W:0] full;
  assign full = (SUM_W+1)'(acc) + (SUM_W+1)'(beat);
  // carry out means the true sum exceeded all-ones; an all-ones acc keeps saturating
  assign sum = full[SUM_W] ? '1 : full[SUM_W-1:0];
`else
  assign sum = acc + SUM_W'(beat);
`endif
endmodule

// File: rtl/frame_accum.sv
// frame_accum: sums every COUNT accepted beats into a frame total on a valid/retry port.
// Build option FRAME_ACCUM_SAT_EN selects saturating instead of wrapping addition.
module frame_accum
  import frame_accum_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int SUM_W = SUM_W_DEF,
  parameter int COUNT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic [DATA_W-1:0] inp_a,
  input  logic              inpValid,
  output logic              inpRetry,
  output logic [SUM_W-1:0]  total,
  output logic              totalValid,
  input  logic              totalRetry
);
  localparam int CW = cnt_w(COUNT);
  localparam logic [CW-1:0] LAST = CW'(COUNT - 1);
  state_t state, state_nx;
  logic [SUM_W-1:0] acc, sum;
  logic [CW-1:0] cnt;
  logic in_x, out_x, fin;
  accum_add #(.DATA_W(DATA_W), .SUM_W(SUM_W)) u_add (.acc(acc), .beat(inp_a), .sum(sum));
  // a pending total blocks input only while the consumer stalls, so drain and accept overlap
  always_comb begin
    inpRetry = !reset || clear || (state == OUT && totalRetry);
    in_x = inpValid && !inpRetry;
    out_x = totalValid && !totalRetry;
    fin = in_x && cnt == LAST;
    state_nx = clear ? ACC : fin ? OUT : out_x ? ACC : state;
  end
  assign totalValid = state == OUT;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= ACC;
      acc <= '0;
      cnt <= '0;
      total <= '0;
    end else begin
      state <= state_nx;
      if (clear) begin
        acc <= '0;
        cnt <= '0;
      end else if (fin) begin
        total <= sum;
        acc <= '0;
        cnt <= '0;
      end else if (in_x) begin
        acc <= sum;
        cnt <= cnt + 1'b1;
      end
    end
endmodule

// File: tb/tb_frame_accum.sv
// tb_frame_accum: three frame_accum configurations driven in lockstep against a frame-level reference model.
module tb_frame_accum;
  logic clk = 0, reset = 0, clear = 0, inpValid = 0, totalRetry = 0;
  logic [7:0] inp_a = 0;
  logic r0, r8, r1, v0, v8, v1;
  logic [15:0] t0, t1;
  logic [7:0] t8;
  int total = 0, bad = 0;
  int lim[3] = '{4, 4, 1};
  int wid[3] = '{16, 8, 16};
  int nb[3], psum[3], pt[3];
  bit pv[3];

  always #5 clk = ~clk;

  frame_accum dut0 (.clk(clk), .reset(reset), .clear(clear), .inp_a(inp_a), .inpValid(inpValid),
    .inpRetry(r0), .total(t0), .totalValid(v0), .totalRetry(totalRetry));
  frame_accum #(.SUM_W(8)) dut8 (.clk(clk), .reset(reset), .clear(clear), .inp_a(inp_a), .inpValid(inpValid),
    .inpRetry(r8), .total(t8), .totalValid(v8), .totalRetry(totalRetry));
  frame_accum #(.COUNT(1)) dut1 (.clk(clk), .reset(reset), .clear(clear), .inp_a(inp_a), .inpValid(inpValid),
    .inpRetry(r1), .total(t1), .totalValid(v1), .totalRetry(totalRetry));

  function automatic int fold(input int s, input int w);
`ifdef FRAME_ACCUM_SAT_EN
    return s > (1 << w) - 1 ? (1 << w) - 1 : s;
`else
    return s % (1 << w);
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  function automatic logic [15:0] tot_of(input int i);
    return i == 0 ? t0 : i == 1 ? {8'h00, t8} : t1;
  endfunction

  function automatic logic rt_of(input int i);
    return i == 0 ? r0 : i == 1 ? r8 : r1;
  endfunction

  function automatic logic vl_of(input int i);
    return i == 0 ? v0 : i == 1 ? v8 : v1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      nb[i] = 0; psum[i] = 0; pt[i] = 0; pv[i] = 0;
    end
  endtask

  // one clock: check retry before the edge, advance the model at the edge, check outputs after it
  task automatic tick();
    bit ix[3], ox[3];
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("retry%0d", i), 32'(rt_of(i)), 32'(clear || (pv[i] && totalRetry)));
      ix[i] = inpValid && !(clear || (pv[i] && totalRetry));
      ox[i] = pv[i] && !totalRetry;
    end
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (clear) begin
        nb[i] = 0; psum[i] = 0; pv[i] = 0;
      end else begin
        if (ox[i]) pv[i] = 0;
        if (ix[i]) begin
          psum[i] += int'(inp_a);
          nb[i]++;
          if (nb[i] == lim[i]) begin
            pt[i] = fold(psum[i], wid[i]);
            pv[i] = 1;
            nb[i] = 0;
            psum[i] = 0;
          end
        end
      end
    end
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("valid%0d", i), 32'(vl_of(i)), 32'(pv[i]));
      chk($sformatf("total%0d", i), 32'(tot_of(i)), 32'(pt[i]));
    end
  endtask

  task automatic beat(input logic v, input logic [7:0] a, input logic tr);
    inpValid = v; inp_a = a; totalRetry = tr;
    tick();
  endtask

  initial begin
    model_reset();
    #12;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_valid%0d", i), 32'(vl_of(i)), 0);
      chk($sformatf("rst_total%0d", i), 32'(tot_of(i)), 0);
      chk($sformatf("rst_retry%0d", i), 32'(rt_of(i)), 1);
    end
    reset = 1;
    // plain frame with no back-pressure, then idle to see the one-cycle valid
    for (int k = 1; k <= 4; k++) beat(1, 8'(k), 0);
    chk("t1_total", 32'(t0), 10);
    beat(0, 0, 0);
    // stalled consumer: total holds, input blocked, then drain and accept together
    for (int k = 0; k < 4; k++) beat(1, 1, 0);
    for (int k = 0; k < 5; k++) beat(1, 9, 1);
    chk("t2_hold", 32'(t0), 4);
    beat(1, 9, 0);
    for (int k = 0; k < 3; k++) beat(1, 1, 0);
    beat(0, 0, 0);
    // all-ones beats exercise wrap or saturation in the narrow build
    for (int k = 0; k < 4; k++) beat(1, 8'hff, 0);
    beat(0, 0, 0);
    // clear discards a partial frame and blocks the beat offered alongside it
    beat(1, 5, 0);
    beat(1, 6, 0);
    clear = 1;
    beat(1, 9, 0);
    clear = 0;
    for (int k = 0; k < 4; k++) beat(1, 1, 0);
    chk("t4_total", 32'(t0), 4);
    beat(0, 0, 0);
    // async reset while a total is pending
    for (int k = 1; k <= 4; k++) beat(1, 8'(k), 0);
    beat(1, 7, 1);
    #2;
    reset = 0;
    #1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("arst_valid%0d", i), 32'(vl_of(i)), 0);
      chk($sformatf("arst_total%0d", i), 32'(tot_of(i)), 0);
      chk($sformatf("arst_retry%0d", i), 32'(rt_of(i)), 1);
    end
    #9;
    reset = 1;
    for (int k = 0; k < 4; k++) beat(1, 2, 0);
    chk("t5_total", 32'(t0), 8);
    // back-to-back single-beat frames
    beat(1, 7, 0);
    chk("t6_a", 32'(t1), 7);
    beat(1, 8, 0);
    chk("t6_b", 32'(t1), 8);
    beat(1, 9, 0);
    chk("t6_c", 32'(t1), 9);
    beat(0, 0, 0);
    // random traffic with back-pressure and occasional clears
    for (int k = 0; k < 400; k++) begin
      clear = $urandom_range(0, 29) == 0;
      beat($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) == 0);
    end
    clear = 0;
    beat(0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
